// File: rtl/stat_resp_misr.sv
// stat_resp_misr: response compactor for the Stat benchmark harness.
// Folds one WIDTH-bit response vector per handshake into a MISR, then
// compares the final signature with a golden value and reports pass/fail.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// st_idle  | waiting for start after reset
// st_accum | accepting response vectors, one per transfer
// st_final | one cycle to compare the signature against golden
// st_done  | result held; a new start may be accepted
module stat_resp_misr #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] POLY    = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED    = '0,
    parameter int               COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_vectors,
    input  logic [WIDTH-1:0]   golden,
    input  logic               resp_valid,
    input  logic [WIDTH-1:0]   resp_data,
    output logic               resp_ready,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [WIDTH-1:0]   signature,
    output logic [COUNT_W-1:0] vec_count
);

    typedef enum logic [1:0] {
        st_idle,
        st_accum,
        st_final,
        st_done
    } state_t;

    state_t             state;
    logic [COUNT_W-1:0] num_lat;
    logic [WIDTH-1:0]   misr_next;
    logic               xfer;

    // Next MISR value: shift left, fold the polynomial on a carry-out, mix in data.
    always_comb begin
        misr_next = {signature[WIDTH-2:0], 1'b0} ^ resp_data;
        if (signature[WIDTH-1]) begin
            misr_next = misr_next ^ POLY;
        end
    end

    // resp_ready is only ever high in st_accum, so this is the transfer strobe.
    assign xfer = resp_valid & resp_ready;

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= st_idle;
            signature  <= SEED;
            vec_count  <= '0;
            num_lat    <= '0;
            resp_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            case (state)
                st_idle, st_done: begin
                    if (start) begin
                        signature <= SEED;
                        vec_count <= '0;
                        num_lat   <= num_vectors;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        if (num_vectors != '0) begin
                            resp_ready <= 1'b1;
                            state      <= st_accum;
                        end else begin
                            state <= st_final;
                        end
                    end
                end
                st_accum: begin
                    if (xfer) begin
                        signature <= misr_next;
                        vec_count <= vec_count + COUNT_W'(1);
                        if (vec_count == num_lat - COUNT_W'(1)) begin
                            resp_ready <= 1'b0;
                            state      <= st_final;
                        end
                    end
                end
                st_final: begin
                    pass  <= (signature == golden);
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= st_done;
                end
                default: begin
                    state      <= st_idle;
                    resp_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stat_resp_misr.sv
// Directed testbench for stat_resp_misr with hand-computed MISR values.
module tb_stat_resp_misr;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_vectors;
    logic [31:0] golden;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;
    logic [15:0] vec_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] vecs [4];
    logic [31:0] sigs [4];

    stat_resp_misr dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_vectors(num_vectors),
        .golden     (golden),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .vec_count  (vec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge; inputs change and outputs are sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start       = 1'b1;
        num_vectors = n;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) tick();
        resp_valid = 1'b0;
        total++;
        if ({resp_ready, busy, done, pass} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000", {resp_ready, busy, done, pass});
        end
        total++;
        if (signature !== 32'h0) begin
            bad++;
            $display("FAIL reset_sig: got %h want 00000000", signature);
        end
        total++;
        if (vec_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d want 0", vec_count);
        end
    endtask

    task automatic test_back_to_back();
        golden = 32'h04C11DBB;
        do_start(16'd4);
        total++;
        if ({resp_ready, busy, done} !== 3'b110) begin
            bad++;
            $display("FAIL b2b_accum_flags: got %b want 110", {resp_ready, busy, done});
        end
        for (int i = 0; i < 4; i++) begin
            resp_valid = 1'b1;
            resp_data  = vecs[i];
            tick();
            total++;
            if (signature !== sigs[i] || vec_count !== 16'(i + 1)) begin
                bad++;
                $display("FAIL b2b_sig%0d: got %h/%0d want %h/%0d", i, signature, vec_count, sigs[i], i + 1);
            end
        end
        resp_valid = 1'b0;
        total++;
        if ({resp_ready, busy, done} !== 3'b010) begin
            bad++;
            $display("FAIL b2b_final_flags: got %b want 010", {resp_ready, busy, done});
        end
        tick();
        total++;
        if ({busy, done, pass} !== 3'b011 || vec_count !== 16'd4) begin
            bad++;
            $display("FAIL b2b_done: got busy/done/pass %b cnt %0d want 011 cnt 4", {busy, done, pass}, vec_count);
        end
    endtask

    task automatic test_restart();
        golden = 32'hFFFFFFFF;
        do_start(16'd1);
        total++;
        if ({done, pass, resp_ready} !== 3'b001) begin
            bad++;
            $display("FAIL restart_clear: got done/pass/ready %b want 001", {done, pass, resp_ready});
        end
        resp_valid = 1'b1;
        resp_data  = 32'hFFFFFFFF;
        tick();
        resp_valid = 1'b0;
        tick();
        total++;
        if (signature !== 32'hFFFFFFFF || {done, pass} !== 2'b11 || vec_count !== 16'd1) begin
            bad++;
            $display("FAIL restart_result: got %h done/pass %b cnt %0d want ffffffff 11 cnt 1", signature, {done, pass}, vec_count);
        end
        resp_valid = 1'b1;
        resp_data  = 32'h12345678;
        tick();
        tick();
        resp_valid = 1'b0;
        total++;
        if (signature !== 32'hFFFFFFFF || vec_count !== 16'd1 || resp_ready !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL done_hold: got %h cnt %0d ready %b done %b want ffffffff 1 0 1", signature, vec_count, resp_ready, done);
        end
    endtask

    task automatic test_toggle();
        golden = 32'h04C11DBA;
        do_start(16'd4);
        for (int i = 0; i < 4; i++) begin
            resp_valid = 1'b0;
            resp_data  = 32'hA5A5A5A5;
            tick();
            total++;
            if (vec_count !== 16'(i)) begin
                bad++;
                $display("FAIL tog_idle%0d: got cnt %0d want %0d", i, vec_count, i);
            end
            resp_valid = 1'b1;
            resp_data  = vecs[i];
            tick();
            total++;
            if (signature !== sigs[i]) begin
                bad++;
                $display("FAIL tog_sig%0d: got %h want %h", i, signature, sigs[i]);
            end
        end
        resp_valid = 1'b0;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL tog_early_done: got %b want 0", done);
        end
        tick();
        total++;
        if ({done, pass} !== 2'b10 || signature !== 32'h04C11DBB) begin
            bad++;
            $display("FAIL tog_result: got done/pass %b sig %h want 10 04c11dbb", {done, pass}, signature);
        end
    endtask

    task automatic test_zero();
        golden = 32'h0;
        do_start(16'd0);
        total++;
        if ({resp_ready, busy, done} !== 3'b010) begin
            bad++;
            $display("FAIL zero_final: got ready/busy/done %b want 010", {resp_ready, busy, done});
        end
        tick();
        total++;
        if ({done, pass} !== 2'b11 || signature !== 32'h0 || vec_count !== 16'd0) begin
            bad++;
            $display("FAIL zero_done: got done/pass %b sig %h cnt %0d want 11 0 0", {done, pass}, signature, vec_count);
        end
    endtask

    task automatic test_start_ignored();
        golden = 32'h04C11DBB;
        do_start(16'd4);
        for (int i = 0; i < 2; i++) begin
            resp_valid = 1'b1;
            resp_data  = vecs[i];
            tick();
        end
        resp_valid = 1'b0;
        start       = 1'b1;
        num_vectors = 16'd1;
        tick();
        start = 1'b0;
        total++;
        if (signature !== 32'h3 || vec_count !== 16'd2 || resp_ready !== 1'b1) begin
            bad++;
            $display("FAIL ign_start: got %h cnt %0d ready %b want 00000003 2 1", signature, vec_count, resp_ready);
        end
        for (int i = 2; i < 4; i++) begin
            resp_valid = 1'b1;
            resp_data  = vecs[i];
            tick();
        end
        resp_valid = 1'b0;
        tick();
        total++;
        if ({done, pass} !== 2'b11 || vec_count !== 16'd4 || signature !== 32'h04C11DBB) begin
            bad++;
            $display("FAIL ign_result: got done/pass %b cnt %0d sig %h want 11 4 04c11dbb", {done, pass}, vec_count, signature);
        end
    endtask

    task automatic test_rst_abort();
        do_start(16'd4);
        for (int i = 0; i < 2; i++) begin
            resp_valid = 1'b1;
            resp_data  = vecs[i];
            tick();
        end
        resp_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({resp_ready, busy, done, pass} !== 4'b0000 || signature !== 32'h0 || vec_count !== 16'd0) begin
            bad++;
            $display("FAIL rst_abort: got flags %b sig %h cnt %0d want 0000 0 0", {resp_ready, busy, done, pass}, signature, vec_count);
        end
        resp_valid = 1'b1;
        resp_data  = 32'h1;
        tick();
        resp_valid = 1'b0;
        total++;
        if (signature !== 32'h0 || vec_count !== 16'd0) begin
            bad++;
            $display("FAIL idle_ignore: got sig %h cnt %0d want 0 0", signature, vec_count);
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_vectors = '0;
        golden      = '0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        vecs[0] = 32'h00000001; sigs[0] = 32'h00000001;
        vecs[1] = 32'h00000001; sigs[1] = 32'h00000003;
        vecs[2] = 32'h80000000; sigs[2] = 32'h80000006;
        vecs[3] = 32'h00000000; sigs[3] = 32'h04C11DBB;
        #2;
        test_reset();
        test_back_to_back();
        test_restart();
        test_toggle();
        test_zero();
        test_start_ignored();
        test_rst_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
